// File: rtl/board_pkg.sv
// board_pkg: cell codes, FSM encoding, line table and one-hot helpers for the board-state writer
package board_pkg;
    typedef logic [1:0] cel_t;
    localparam cel_t CEL_ANDAMENTO = 2'b00;
    localparam cel_t CEL_X         = 2'b01;
    localparam cel_t CEL_O         = 2'b10;
    localparam cel_t CEL_EMPATE    = 2'b11;
    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_LIMPA        = 4'd1;
    localparam logic [3:0] S_CHECA        = 4'd2;
    localparam logic [3:0] S_GRAVA_MICRO  = 4'd3;
    localparam logic [3:0] S_AVALIA_MICRO = 4'd4;
    localparam logic [3:0] S_GRAVA_MACRO  = 4'd5;
    localparam logic [3:0] S_AVALIA_MACRO = 4'd6;
    localparam logic [3:0] S_FIM          = 4'd7;
    localparam logic [3:0] S_FIM_JOGO     = 4'd8;
    // rows, columns, diagonals; entry 0 is the top row
    localparam logic [7:0][2:0][3:0] LINHAS = {
        {4'd2, 4'd4, 4'd6}, {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd5, 4'd8}, {4'd1, 4'd4, 4'd7}, {4'd0, 4'd3, 4'd6},
        {4'd6, 4'd7, 4'd8}, {4'd3, 4'd4, 4'd5}, {4'd0, 4'd1, 4'd2}
    };
    function automatic logic um_quente(input logic [8:0] v);
        return v != 9'd0 && (v & (v - 9'd1)) == 9'd0;
    endfunction
    function automatic logic [3:0] indice(input logic [8:0] v);
        indice = 4'd0;
        for (int i = 0; i < 9; i++)
            if (v[i]) indice = 4'(i);
    endfunction
endpackage

// File: rtl/avaliador_tabuleiro.sv
// avaliador_tabuleiro: combinational win/draw evaluation of one 3x3 board
import board_pkg::*;
module avaliador_tabuleiro (
    input  logic [8:0][1:0] tabuleiro,
    output logic [1:0]      resultado
);
    cel_t a, b, c;
    logic cheio;
    always_comb begin
        resultado = CEL_ANDAMENTO;
        cheio = 1'b1;
        a = CEL_ANDAMENTO;
        b = CEL_ANDAMENTO;
        c = CEL_ANDAMENTO;
        for (int k = 0; k < 9; k++)
            if (tabuleiro[k] == CEL_ANDAMENTO) cheio = 1'b0;
        // drawn cells (11) never complete a line
        for (int l = 0; l < 8; l++) begin
            a = tabuleiro[LINHAS[l][0]];
            b = tabuleiro[LINHAS[l][1]];
            c = tabuleiro[LINHAS[l][2]];
            if (a == b && b == c && (a == CEL_X || a == CEL_O)) resultado = a;
        end
        resultado = (resultado == CEL_ANDAMENTO && cheio) ? CEL_EMPATE : resultado;
    end
endmodule

// File: rtl/board_state_writer.sv
// board_state_writer: records moves in 81 micro cells, decides micro boards
// and writes their results to ram_board_state, detecting end of game
import board_pkg::*;
module board_state_writer #(
    parameter int N_CELULAS = 9,
    parameter int ADDR_W    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 registra,
    input  logic [N_CELULAS-1:0] macro,
    input  logic [N_CELULAS-1:0] micro,
    input  logic                 jogador,
    output logic                 ocupado,
    output logic                 pronto,
    output logic                 jogada_invalida,
    output logic                 micro_vencido,
    output logic                 fim_jogo,
    output logic [1:0]           vencedor,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [1:0]           ram_data,
    output logic [3:0]           db_estado
);
    logic [3:0] estado, cnt, mac_idx, mic_idx;
    logic [8:0] mac_reg, mic_reg;
    logic jog_reg, inval, venceu;
    logic [8:0][8:0][1:0] micro_tab;
    logic [8:0][1:0] mac_tab;
    logic [1:0] res_micro, res_macro;
    logic invalida;

    assign mac_idx = indice(mac_reg);
    assign mic_idx = indice(mic_reg);
    assign invalida = !um_quente(mac_reg) || !um_quente(mic_reg) ||
                      mac_tab[mac_idx] != CEL_ANDAMENTO ||
                      micro_tab[mac_idx][mic_idx] != CEL_ANDAMENTO;

    avaliador_tabuleiro u_micro (.tabuleiro(micro_tab[mac_idx]), .resultado(res_micro));
    avaliador_tabuleiro u_macro (.tabuleiro(mac_tab), .resultado(res_macro));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= S_IDLE;
            cnt       <= '0;
            mac_reg   <= '0;
            mic_reg   <= '0;
            jog_reg   <= 1'b0;
            inval     <= 1'b0;
            venceu    <= 1'b0;
            vencedor  <= CEL_ANDAMENTO;
            micro_tab <= '0;
            mac_tab   <= '0;
        end else begin
            case (estado)
                S_IDLE: begin
                    if (iniciar) begin
                        cnt    <= '0;
                        estado <= S_LIMPA;
                    end else if (registra) begin
                        mac_reg <= macro;
                        mic_reg <= micro;
                        jog_reg <= jogador;
                        inval   <= 1'b0;
                        venceu  <= 1'b0;
                        estado  <= S_CHECA;
                    end
                end
                S_LIMPA: begin
                    if (cnt == 4'd0) begin
                        micro_tab <= '0;
                        mac_tab   <= '0;
                    end
                    cnt    <= cnt + 4'd1;
                    estado <= (cnt == 4'd8) ? S_IDLE : S_LIMPA;
                end
                S_CHECA: begin
                    inval  <= invalida;
                    estado <= invalida ? S_FIM : S_GRAVA_MICRO;
                end
                S_GRAVA_MICRO: begin
                    micro_tab[mac_idx][mic_idx] <= jog_reg ? CEL_O : CEL_X;
                    estado <= S_AVALIA_MICRO;
                end
                S_AVALIA_MICRO: estado <= (res_micro != CEL_ANDAMENTO) ? S_GRAVA_MACRO : S_FIM;
                S_GRAVA_MACRO: begin
                    mac_tab[mac_idx] <= res_micro;
                    venceu <= 1'b1;
                    estado <= S_AVALIA_MACRO;
                end
                S_AVALIA_MACRO: begin
                    if (res_macro != CEL_ANDAMENTO) vencedor <= res_macro;
                    estado <= (res_macro != CEL_ANDAMENTO) ? S_FIM_JOGO : S_FIM;
                end
                S_FIM: estado <= S_IDLE;
                S_FIM_JOGO: begin
                    if (iniciar) begin
                        vencedor <= CEL_ANDAMENTO;
                        cnt      <= '0;
                        estado   <= S_LIMPA;
                    end
                end
                default: estado <= S_IDLE;
            endcase
        end
    end

    assign ocupado         = !(estado == S_IDLE || estado == S_FIM_JOGO);
    assign pronto          = estado == S_FIM;
    assign jogada_invalida = pronto && inval;
    assign micro_vencido   = pronto && venceu;
    assign fim_jogo        = estado == S_FIM_JOGO;
    assign ram_we          = estado == S_LIMPA || estado == S_GRAVA_MACRO;
    assign ram_addr        = ADDR_W'(estado == S_LIMPA ? cnt : estado == S_GRAVA_MACRO ? mac_idx : 4'd0);
    assign ram_data        = estado == S_GRAVA_MACRO ? res_micro : CEL_ANDAMENTO;
    assign db_estado       = estado;
endmodule

// File: tb/tb_board_state_writer.sv
// tb_board_state_writer: directed-vector bench with hand-computed expectations
module tb_board_state_writer;
    logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, registra = 1'b0, jogador = 1'b0;
    logic [8:0] macro = '0, micro = '0;
    logic ocupado, pronto, jogada_invalida, micro_vencido, fim_jogo, ram_we;
    logic [1:0] vencedor, ram_data;
    logic [3:0] ram_addr, db_estado;
    int checks = 0, failures = 0, qviol = 0;
    int pc, wc, wa, wd, nw, fc;
    logic inv, mv;

    always #5 clock = ~clock;

    board_state_writer dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .registra(registra),
        .macro(macro), .micro(micro), .jogador(jogador), .ocupado(ocupado),
        .pronto(pronto), .jogada_invalida(jogada_invalida), .micro_vencido(micro_vencido),
        .fim_jogo(fim_jogo), .vencedor(vencedor), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .db_estado(db_estado)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // issues one move and observes 11 cycles; c counts cycles after registra
    task automatic move(input logic [8:0] m, input logic [8:0] u, input logic j);
        macro = m; micro = u; jogador = j; registra = 1'b1;
        tick();
        registra = 1'b0;
        pc = -1; wc = -1; wa = -1; wd = -1; nw = 0; fc = -1; inv = 1'b0; mv = 1'b0;
        for (int c = 1; c < 12; c++) begin
            if (ram_we) begin nw++; wc = c; wa = int'(ram_addr); wd = int'(ram_data); end
            if (pronto && pc < 0) begin pc = c; inv = jogada_invalida; mv = micro_vencido; end
            if (fim_jogo && fc < 0) fc = c;
            if (!pronto && (jogada_invalida || micro_vencido)) qviol++;
            tick();
        end
    endtask

    logic [8:0] draw_cells [9] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h100};
    logic       draw_jog   [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_pronto", int'(pronto), 0);
        check("rst_we", int'(ram_we), 0);
        check("rst_fim", int'(fim_jogo), 0);
        check("rst_venc", int'(vencedor), 0);
        check("rst_estado", int'(db_estado), 0);

        iniciar = 1'b1; tick(); iniciar = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("limpa_we", int'(ram_we), 1);
            check("limpa_addr", int'(ram_addr), i);
            check("limpa_data", int'(ram_data), 0);
            tick();
        end
        check("limpa_fim_we", int'(ram_we), 0);
        check("limpa_fim_ocupado", int'(ocupado), 0);
        check("limpa_fim_estado", int'(db_estado), 0);

        move(9'h001, 9'h010, 1'b0);
        check("plain_pc", pc, 4);
        check("plain_nw", nw, 0);
        check("plain_inv", int'(inv), 0);
        check("plain_mv", int'(mv), 0);
        move(9'h001, 9'h001, 1'b0);
        check("plain2_pc", pc, 4);
        move(9'h001, 9'h100, 1'b0);
        check("win0_wc", wc, 4);
        check("win0_addr", wa, 0);
        check("win0_data", wd, 1);
        check("win0_nw", nw, 1);
        check("win0_pc", pc, 6);
        check("win0_mv", int'(mv), 1);
        check("win0_inv", int'(inv), 0);

        move(9'h001, 9'h010, 1'b0);
        check("rep_pc", pc, 2); check("rep_inv", int'(inv), 1); check("rep_nw", nw, 0);
        move(9'h001, 9'h002, 1'b1);
        check("decided_pc", pc, 2); check("decided_inv", int'(inv), 1);
        move(9'h002, 9'h003, 1'b0);
        check("micro2hot_pc", pc, 2); check("micro2hot_inv", int'(inv), 1); check("micro2hot_nw", nw, 0);
        move(9'h003, 9'h001, 1'b0);
        check("macro2hot_inv", int'(inv), 1);
        move(9'h002, 9'h000, 1'b0);
        check("microzero_inv", int'(inv), 1);

        for (int i = 0; i < 9; i++) move(9'h008, draw_cells[i], draw_jog[i]);
        check("draw_wc", wc, 4);
        check("draw_addr", wa, 3);
        check("draw_data", wd, 3);
        check("draw_pc", pc, 6);
        check("draw_mv", int'(mv), 1);

        // macro 6 first: line 0,3,6 holds X, draw, X and must not end the game
        move(9'h040, 9'h040, 1'b0); move(9'h040, 9'h080, 1'b0); move(9'h040, 9'h100, 1'b0);
        check("m6_addr", wa, 6); check("m6_pc", pc, 6); check("m6_fim", fc, -1);
        move(9'h004, 9'h001, 1'b0); move(9'h004, 9'h002, 1'b0); move(9'h004, 9'h004, 1'b0);
        check("m2_addr", wa, 2); check("m2_fim", fc, -1);
        move(9'h010, 9'h008, 1'b0); move(9'h010, 9'h010, 1'b0); move(9'h010, 9'h020, 1'b0);
        check("m4_wc", wc, 4); check("m4_addr", wa, 4); check("m4_data", wd, 1);
        check("m4_pc", pc, -1);
        check("m4_fc", fc, 6);
        check("end_fim", int'(fim_jogo), 1);
        check("end_venc", int'(vencedor), 1);
        check("end_estado", int'(db_estado), 8);
        check("end_ocupado", int'(ocupado), 0);

        move(9'h100, 9'h001, 1'b0);
        check("ign_pc", pc, -1); check("ign_nw", nw, 0);
        check("ign_fim", int'(fim_jogo), 1); check("ign_venc", int'(vencedor), 1);

        iniciar = 1'b1; tick(); iniciar = 1'b0;
        check("ini_fim", int'(fim_jogo), 0);
        check("ini_venc", int'(vencedor), 0);
        check("ini_we", int'(ram_we), 1);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("arst_estado", int'(db_estado), 0);
        check("arst_we", int'(ram_we), 0);
        check("arst_ocupado", int'(ocupado), 0);
        reset = 1'b0;

        move(9'h001, 9'h010, 1'b0);
        check("post_pc", pc, 4); check("post_inv", int'(inv), 0);
        check("qual_no_pronto", qviol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
